// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial arithmetic units (adder now, subtractor later).
// Holds the state encoding, the default operand width and the bit-level carry helper.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Majority of three: the carry out of a one-bit full add.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder_bit.sv
// One-bit combinational full adder used as the serial adder's per-cycle datapath.
module full_adder_bit
    import serial_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = maj3(a, b, cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock LSB first,
// with valid/ready handshakes on the operand and result sides.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    state_t             state_reg;
    logic [WIDTH-1:0]   a_sr_reg;
    logic [WIDTH-1:0]   b_sr_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic [WIDTH-1:0]   sum_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic               carry_reg;
    logic               cout_reg;
    logic               ovf_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic               fa_s;
    logic               fa_cout;
    logic               last_step;

    full_adder_bit u_fa (
        .a    (a_sr_reg[0]),
        .b    (b_sr_reg[0]),
        .cin  (carry_reg),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Each new result bit enters at the MSB, so after WIDTH steps bit 0 sits at the LSB.
    assign sum_next  = {fa_s, sum_reg[WIDTH-1:1]};
    assign last_step = (cnt_reg == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            a_sr_reg      <= '0;
            b_sr_reg      <= '0;
            sum_reg       <= '0;
            cnt_reg       <= '0;
            carry_reg     <= 1'b0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        a_sr_reg     <= a;
                        b_sr_reg     <= b;
                        carry_reg    <= cin;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_sr_reg  <= {1'b0, a_sr_reg[WIDTH-1:1]};
                    b_sr_reg  <= {1'b0, b_sr_reg[WIDTH-1:1]};
                    carry_reg <= fa_cout;
                    sum_reg   <= sum_next;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (last_step) begin
                        // carry_reg here is the carry into the MSB; compare with carry out.
                        cout_reg      <= fa_cout;
                        ovf_reg       <= carry_reg ^ fa_cout;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder: arithmetic, latency, backpressure, reset abort, sweep.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_vec = 0;
    int n_mis = 0;
    time last_accept = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction. hold>0 keeps out_ready low that many DONE cycles;
    // noise drives junk operands with in_valid high while the op is in flight.
    task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                         input logic tc, input logic [8:0] exp_res, input logic exp_ovf,
                         input int hold, input bit noise, input bit chk_spacing);
        int k;
        int lat;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        out_ready = (hold == 0);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        @(posedge clk);
        if (chk_spacing)
            check({tag, " spacing"}, 32'($time - last_accept), 32'(10 * (WIDTH + 2)));
        last_accept = $time;
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1)
                check({tag, " busy"}, 32'(in_ready), 32'd0);
            if (noise && lat == 2) begin
                a = 8'h5A; b = 8'hC3; cin = 1'b1; in_valid = 1'b1;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(WIDTH));
        check({tag, " sum"}, 32'(sum), 32'(exp_res[7:0]));
        check({tag, " cout"}, 32'(cout), 32'(exp_res[8]));
        check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold result"}, 32'({ovf, cout, sum}), 32'({exp_ovf, exp_res}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " handoff"}, 32'({out_valid, in_ready}), 32'b01);
        $display("op %s: a=%0d b=%0d cin=%0d -> sum=%0d cout=%0d ovf=%0d lat=%0d",
                 tag, ta, tb, tc, sum, cout, ovf, lat);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset outs", 32'({in_ready, out_valid, cout, ovf}), 32'b1000);
        check("reset sum", 32'(sum), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1, T2, T3
        do_op("t1 zero", 8'd0, 8'd0, 1'b0, 9'd0, 1'b0, 0, 1'b0, 1'b0);
        do_op("t2 wrap", 8'd255, 8'd1, 1'b0, 9'h100, 1'b0, 0, 1'b0, 1'b0);
        do_op("t2 sovf", 8'd127, 8'd1, 1'b0, 9'd128, 1'b1, 0, 1'b0, 1'b0);
        do_op("t3 cin", 8'd100, 8'd27, 1'b1, 9'd128, 1'b1, 0, 1'b0, 1'b0);
        do_op("t3 carry", 8'd200, 8'd100, 1'b1, 9'd301, 1'b0, 0, 1'b0, 1'b0);

        // T4 backpressure with ignored operands
        do_op("t4 bp", 8'd200, 8'd100, 1'b1, 9'd301, 1'b0, 5, 1'b1, 1'b0);
        do_op("t4 noise", 8'd3, 8'd4, 1'b0, 9'd7, 1'b0, 0, 1'b1, 1'b0);

        // T5 asynchronous reset mid-SHIFT
        a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t5 rst ctl", 32'({in_ready, out_valid}), 32'b10);
        check("t5 rst res", 32'({ovf, cout, sum}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        do_op("t5 after", 8'd5, 8'd9, 1'b0, 9'd14, 1'b0, 0, 1'b0, 1'b0);

        // T6 sweep, back-to-back
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                for (int c = 0; c < 2; c++)
                    do_op($sformatf("t6 %0d+%0d+%0d", i, j, c), 8'(i), 8'(j), 1'(c),
                          9'(i + j + c), 1'b0, 0, 1'b0, !(i == 0 && j == 0 && c == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
